// File: rtl/snn_layer_scheduler.sv
// Sequencer for the shared MAC/neuron datapath: timesteps x neurons x synapses.
// Latency: NUM_STEPS*NUM_NEURONS*(NUM_INPUTS+4) cycles from start to done with an immediate upd_done.
// Backpressure: upd_done stalls the walk in WAIT_UPD; start while busy is dropped, abort always wins.
//
// Ports:
//   clk, rst        rising-edge clock, asynchronous active-low reset
//   start, abort    run request (IDLE only) and synchronous cancel
//   upd_done        neuron update unit finished the requested neuron
//   busy, done      run in progress / one-cycle completion pulse
//   step_idx        current timestep
//   neuron_idx      current neuron
//   input_idx       current synapse address for the weight/spike memories
//   rd_en           memory read strobe
//   acc_clr         accumulator clear
//   acc_en          accumulate strobe
//   upd_en          one-cycle neuron update request
module snn_layer_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int NUM_INPUTS  = 8,
  parameter int NUM_STEPS   = 4,
  parameter int IDX_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             upd_done,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] step_idx,
  output logic [IDX_W-1:0] neuron_idx,
  output logic [IDX_W-1:0] input_idx,
  output logic             rd_en,
  output logic             acc_clr,
  output logic             acc_en,
  output logic             upd_en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FETCH,
    S_DRAIN,
    S_UPDATE,
    S_WAIT_UPD,
    S_DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IN  = IDX_W'(NUM_INPUTS - 1);
  localparam logic [IDX_W-1:0] LAST_NRN = IDX_W'(NUM_NEURONS - 1);
  localparam logic [IDX_W-1:0] LAST_STP = IDX_W'(NUM_STEPS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  state_t state;

  // Every output is computed together with the next state so that the
  // strobes appear in the same cycle as the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      step_idx   <= '0;
      neuron_idx <= '0;
      input_idx  <= '0;
      rd_en      <= 1'b0;
      acc_clr    <= 1'b0;
      acc_en     <= 1'b0;
      upd_en     <= 1'b0;
    end else begin
      // Strobes default low; acc_en trails rd_en by the one-cycle read latency.
      rd_en   <= 1'b0;
      acc_clr <= 1'b0;
      upd_en  <= 1'b0;
      done    <= 1'b0;
      acc_en  <= rd_en;

      if (abort && (state != S_IDLE)) begin
        // Cancel: drop everything, including the accumulate owed to the
        // read issued this cycle.
        state      <= S_IDLE;
        busy       <= 1'b0;
        acc_en     <= 1'b0;
        step_idx   <= '0;
        neuron_idx <= '0;
        input_idx  <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            step_idx   <= '0;
            neuron_idx <= '0;
            input_idx  <= '0;
            if (start && !abort) begin
              state   <= S_CLEAR;
              busy    <= 1'b1;
              acc_clr <= 1'b1;
            end
          end

          S_CLEAR: begin
            // First read goes out on the cycle after the clear.
            state     <= S_FETCH;
            input_idx <= '0;
            rd_en     <= 1'b1;
          end

          S_FETCH: begin
            if (input_idx == LAST_IN) begin
              state     <= S_DRAIN;
              input_idx <= '0;
            end else begin
              input_idx <= input_idx + IDX_ONE;
              rd_en     <= 1'b1;
            end
          end

          S_DRAIN: begin
            // The final synapse is accumulated this cycle (acc_en from the
            // last read); the neuron is complete by the next cycle.
            state  <= S_UPDATE;
            upd_en <= 1'b1;
          end

          S_UPDATE: begin
            // upd_done is not looked at here, so an echo in the request
            // cycle cannot end the wait early.
            state <= S_WAIT_UPD;
          end

          S_WAIT_UPD: begin
            if (upd_done) begin
              if (neuron_idx != LAST_NRN) begin
                neuron_idx <= neuron_idx + IDX_ONE;
                state      <= S_CLEAR;
                acc_clr    <= 1'b1;
              end else if (step_idx != LAST_STP) begin
                neuron_idx <= '0;
                step_idx   <= step_idx + IDX_ONE;
                state      <= S_CLEAR;
                acc_clr    <= 1'b1;
              end else begin
                state      <= S_DONE;
                done       <= 1'b1;
                neuron_idx <= '0;
                step_idx   <= '0;
              end
            end
          end

          S_DONE: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end

          default: begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_snn_layer_scheduler.sv
module tb_snn_layer_scheduler;

  localparam int NN  = 2;
  localparam int NI  = 3;
  localparam int NS  = 2;
  localparam int IW  = 8;
  localparam int NN8 = 2;
  localparam int NI8 = 8;
  localparam int NS8 = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic start = 1'b0, abort = 1'b0, upd_done = 1'b0;
  logic busy, done, rd_en, acc_clr, acc_en, upd_en;
  logic [IW-1:0] step_idx, neuron_idx, input_idx;

  logic start8 = 1'b0, abort8 = 1'b0, upd_done8 = 1'b0;
  logic busy8, done8, rd_en8, acc_clr8, acc_en8, upd_en8;
  logic [IW-1:0] step_idx8, neuron_idx8, input_idx8;

  snn_layer_scheduler #(.NUM_NEURONS(NN), .NUM_INPUTS(NI), .NUM_STEPS(NS), .IDX_W(IW)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .upd_done(upd_done),
    .busy(busy), .done(done), .step_idx(step_idx), .neuron_idx(neuron_idx),
    .input_idx(input_idx), .rd_en(rd_en), .acc_clr(acc_clr), .acc_en(acc_en), .upd_en(upd_en)
  );

  snn_layer_scheduler #(.NUM_NEURONS(NN8), .NUM_INPUTS(NI8), .NUM_STEPS(NS8), .IDX_W(IW)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .abort(abort8), .upd_done(upd_done8),
    .busy(busy8), .done(done8), .step_idx(step_idx8), .neuron_idx(neuron_idx8),
    .input_idx(input_idx8), .rd_en(rd_en8), .acc_clr(acc_clr8), .acc_en(acc_en8), .upd_en(upd_en8)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [IW-1:0] stp;
    logic [IW-1:0] nrn;
  } pair_t;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int rd_cnt = 0, acc_cnt = 0, clr_cnt = 0, upd_cnt = 0, done_cnt = 0, done_edge = 0;
  logic prev_rd = 1'b0;
  pair_t exp_q[$];
  logic [IW-1:0] idx_q[$];
  int first_delay = 1;
  bit echo_same = 1'b0;
  int wait_a = 0, wait_b = 0;

  // Watchdog: every wait below is bounded, this only guards against a hang.
  initial begin
    #200000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Monitor for the small DUT: counts strobes, checks the read pipeline and
  // pops the expected (step,neuron) order on every update request.
  initial begin : mon
    pair_t e;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst) begin
        prev_rd = 1'b0;
      end else begin
        checks++;
        if (acc_en !== (prev_rd & ~abort)) begin
          failures++;
          $display("FAIL acc_en_pipe cyc=%0d got=%b exp=%b", cyc, acc_en, prev_rd & ~abort);
        end
        checks++;
        if ((int'(acc_clr) + int'(acc_en) + int'(upd_en)) > 1) begin
          failures++;
          $display("FAIL strobe_excl cyc=%0d got clr=%b acc=%b upd=%b exp at most one", cyc, acc_clr, acc_en, upd_en);
        end
        if (rd_en) rd_cnt++;
        if (acc_en) acc_cnt++;
        if (acc_clr) clr_cnt++;
        if (done) begin
          done_cnt++;
          done_edge = cyc;
        end
        if (upd_en) begin
          upd_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL upd_order cyc=%0d got=(%0d,%0d) exp=none", cyc, step_idx, neuron_idx);
          end else begin
            e = exp_q.pop_front();
            if (step_idx !== e.stp || neuron_idx !== e.nrn) begin
              failures++;
              $display("FAIL upd_order cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)", cyc, step_idx, neuron_idx, e.stp, e.nrn);
            end
          end
        end
        prev_rd = rd_en;
      end
    end
  end

  // Neuron update unit model: upd_done returns first_delay cycles after upd_en.
  initial begin : responder
    forever begin
      @(posedge clk);
      #1;
      upd_done  = 1'b0;
      upd_done8 = 1'b0;
      if (!rst) begin
        wait_a = 0;
        wait_b = 0;
      end else begin
        if (wait_a > 0) begin
          wait_a--;
          if (wait_a == 0) upd_done = 1'b1;
        end
        if (upd_en) begin
          wait_a = first_delay;
          first_delay = 1;
          if (echo_same) upd_done = 1'b1;
        end
        if (wait_b > 0) begin
          wait_b--;
          if (wait_b == 0) upd_done8 = 1'b1;
        end
        if (upd_en8) wait_b = 1;
      end
    end
  end

  task automatic test_reset;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, rd_en, acc_clr, acc_en, upd_en, step_idx, neuron_idx, input_idx} !== '0) begin
      failures++;
      $display("FAIL reset_a got busy=%b done=%b rd=%b idx=%0d/%0d/%0d exp all zero",
               busy, done, rd_en, step_idx, neuron_idx, input_idx);
    end
    checks++;
    if ({busy8, done8, rd_en8, acc_clr8, acc_en8, upd_en8, step_idx8, neuron_idx8, input_idx8} !== '0) begin
      failures++;
      $display("FAIL reset_b got busy=%b done=%b rd=%b exp all zero", busy8, done8, rd_en8);
    end
    rst = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || rd_cnt != 0 || clr_cnt != 0) begin
      failures++;
      $display("FAIL idle_after_reset got busy=%b rd=%0d clr=%0d exp 0/0/0", busy, rd_cnt, clr_cnt);
    end
  endtask

  task automatic test_reset_midrun;
    bit found = 1'b0;
    bit active = 1'b0;
    @(negedge clk) start8 = 1'b1;
    @(negedge clk) start8 = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rd_en8 && input_idx8 == IW'(5)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL midrun_reach got input_idx=%0d exp 5 during FETCH", input_idx8);
    end
    rst = 1'b0;
    #1;
    checks++;
    if ({busy8, done8, rd_en8, acc_clr8, acc_en8, upd_en8, step_idx8, neuron_idx8, input_idx8} !== '0) begin
      failures++;
      $display("FAIL midrun_reset got busy=%b rd=%b acc=%b idx=%0d exp all zero", busy8, rd_en8, acc_en8, input_idx8);
    end
    @(negedge clk) rst = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (busy8 || rd_en8 || acc_clr8 || acc_en8 || upd_en8 || done8) active = 1'b1;
    end
    checks++;
    if (active) begin
      failures++;
      $display("FAIL midrun_quiet got activity=1 exp 0");
    end
  endtask

  task automatic test_pipeline;
    bit prev_rd8 = 1'b0, prev_clr8 = 1'b0, finished = 1'b0;
    int rd8 = 0, acc8 = 0;
    logic [IW-1:0] e;
    idx_q.delete();
    for (int n = 0; n < NN8 * NS8; n++)
      for (int i = 0; i < NI8; i++) idx_q.push_back(IW'(i));
    @(negedge clk) start8 = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      start8 = 1'b0;
      checks++;
      if (acc_en8 !== prev_rd8) begin
        failures++;
        $display("FAIL pipe_acc c=%0d got=%b exp=%b", c, acc_en8, prev_rd8);
      end
      if (rd_en8) begin
        rd8++;
        checks++;
        if (idx_q.size() == 0) begin
          failures++;
          $display("FAIL pipe_idx got=%0d exp=none", input_idx8);
        end else begin
          e = idx_q.pop_front();
          if (input_idx8 !== e) begin
            failures++;
            $display("FAIL pipe_idx got=%0d exp=%0d", input_idx8, e);
          end
        end
        if (!prev_rd8) begin
          checks++;
          if (prev_clr8 !== 1'b1) begin
            failures++;
            $display("FAIL pipe_clr_lead got=%b exp=1", prev_clr8);
          end
        end
      end
      if (acc_en8) acc8++;
      prev_rd8 = rd_en8;
      prev_clr8 = acc_clr8;
      if (done8) begin
        finished = 1'b1;
        break;
      end
    end
    checks++;
    if (!finished || rd8 != NN8 * NS8 * NI8 || acc8 != NN8 * NS8 * NI8 || idx_q.size() != 0) begin
      failures++;
      $display("FAIL pipe_totals got done=%b rd=%0d acc=%0d left=%0d exp 1/%0d/%0d/0",
               finished, rd8, acc8, idx_q.size(), NN8 * NS8 * NI8, NN8 * NS8 * NI8);
    end
  endtask

  task automatic do_run(input string name, input int stall, input int poke);
    int lat_exp, start_edge, quiet_left;
    bit got_done = 1'b0, stall_seen = 1'b0;
    pair_t p, held;
    lat_exp = NS * NN * (NI + 4) + ((stall > 0) ? stall - 1 : 0);
    rd_cnt = 0; acc_cnt = 0; clr_cnt = 0; upd_cnt = 0; done_cnt = 0;
    exp_q.delete();
    for (int s = 0; s < NS; s++)
      for (int n = 0; n < NN; n++) begin
        p.stp = IW'(s);
        p.nrn = IW'(n);
        exp_q.push_back(p);
      end
    if (stall > 0) begin
      first_delay = stall;
      echo_same = 1'b1;
    end
    quiet_left = 0;
    held = '0;
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #2 start_edge = cyc;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (quiet_left > 0) begin
        checks++;
        if ({rd_en, acc_en, acc_clr, upd_en, done, busy} !== 6'b000001 ||
            step_idx !== held.stp || neuron_idx !== held.nrn) begin
          failures++;
          $display("FAIL %s_stall_hold got strobes=%b idx=(%0d,%0d) exp 000001 (%0d,%0d)", name,
                   {rd_en, acc_en, acc_clr, upd_en, done, busy}, step_idx, neuron_idx, held.stp, held.nrn);
        end
        quiet_left--;
      end else if (stall > 0 && !stall_seen && upd_en) begin
        stall_seen = 1'b1;
        quiet_left = stall - 1;
        held.stp = step_idx;
        held.nrn = neuron_idx;
      end
      if (poke > 0 && c == poke) start = 1'b1;
      if (poke > 0 && c == poke + 1) start = 1'b0;
      if (done) begin
        got_done = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start = 1'b0;
    echo_same = 1'b0;
    checks++;
    if (!got_done) begin
      failures++;
      $display("FAIL %s_timeout got no done exp done", name);
    end
    checks++;
    if (done_edge - start_edge != lat_exp) begin
      failures++;
      $display("FAIL %s_latency got=%0d exp=%0d", name, done_edge - start_edge, lat_exp);
    end
    checks++;
    if (rd_cnt != NS * NN * NI || acc_cnt != NS * NN * NI || clr_cnt != NS * NN || upd_cnt != NS * NN) begin
      failures++;
      $display("FAIL %s_counts got rd=%0d acc=%0d clr=%0d upd=%0d exp %0d/%0d/%0d/%0d", name,
               rd_cnt, acc_cnt, clr_cnt, upd_cnt, NS * NN * NI, NS * NN * NI, NS * NN, NS * NN);
    end
    checks++;
    if (exp_q.size() != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL %s_order_left got left=%0d done_cnt=%0d exp 0/1", name, exp_q.size(), done_cnt);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || step_idx !== '0 || neuron_idx !== '0 || input_idx !== '0) begin
      failures++;
      $display("FAIL %s_idle_after got busy=%b done=%b idx=%0d/%0d/%0d exp 0", name,
               busy, done, step_idx, neuron_idx, input_idx);
    end
  endtask

  task automatic test_abort;
    bit found = 1'b0;
    pair_t p;
    rd_cnt = 0; acc_cnt = 0; clr_cnt = 0; upd_cnt = 0; done_cnt = 0;
    exp_q.delete();
    p = '0;
    exp_q.push_back(p);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (rd_en && step_idx == '0 && neuron_idx == IW'(1) && input_idx == IW'(2)) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL abort_reach got no 3rd fetch of neuron 1 exp found");
    end
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    checks++;
    if ({busy, done, rd_en, acc_clr, acc_en, upd_en, step_idx, neuron_idx, input_idx} !== '0) begin
      failures++;
      $display("FAIL abort_idle got busy=%b rd=%b acc=%b idx=%0d/%0d/%0d exp all zero",
               busy, rd_en, acc_en, step_idx, neuron_idx, input_idx);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (done_cnt != 0 || busy !== 1'b0 || exp_q.size() != 0 || rd_cnt != 2 * NI || clr_cnt != 2) begin
      failures++;
      $display("FAIL abort_after got done=%0d busy=%b left=%0d rd=%0d clr=%0d exp 0/0/0/%0d/2",
               done_cnt, busy, exp_q.size(), rd_cnt, clr_cnt, 2 * NI);
    end
    do_run("after_abort", 0, 0);
  endtask

  task automatic test_start_abort_idle;
    clr_cnt = 0;
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || clr_cnt != 0) begin
      failures++;
      $display("FAIL start_abort_idle got busy=%b clr=%0d exp 0/0", busy, clr_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_reset_midrun();
    test_pipeline();
    do_run("full", 0, 0);
    do_run("stall", 10, 0);
    test_abort();
    do_run("busy_start", 0, 10);
    test_start_abort_idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/snn_layer_scheduler.md
Name: snn_layer_scheduler

Overview:
- Sequencing controller for the neural accelerator's shared MAC/neuron datapath.
- On each start it walks NUM_STEPS timesteps × NUM_NEURONS neurons × NUM_INPUTS synapses.
- Drives weight/spike memory reads, accumulator clear/enable strobes and one neuron-update handshake per neuron, then pulses done.
- Replaces the ad-hoc FSM inside top_snn; the datapath becomes a slave of this block.

Parameters:
- NUM_NEURONS, 4, neurons per layer (≥1)
- NUM_INPUTS, 8, synapses per neuron (≥1)
- NUM_STEPS, 4, timesteps per run (≥1)
- IDX_W, 8, width of every index output; each count-1 must fit

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets)
- start  in  1  run request, sampled only in IDLE
- abort  in  1  synchronous cancel
- upd_done  in  1  neuron update unit finished (leak/threshold/fire)
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse at normal completion
- step_idx  out  IDX_W  current timestep
- neuron_idx  out  IDX_W  current neuron
- input_idx  out  IDX_W  read address (synapse) for weight/spike memory
- rd_en  out  1  memory read strobe for input_idx
- acc_clr  out  1  clear accumulator
- acc_en  out  1  accumulate memory data (valid one cycle after rd_en)
- upd_en  out  1  one-cycle request to update neuron_idx

Behaviour:
- Reset (async, rst=0): state=IDLE; all outputs 0.
- All outputs are registered.
- Memory read latency is fixed at 1 cycle. acc_en is rd_en delayed one cycle.
- States: IDLE, CLEAR, FETCH, DRAIN, UPDATE, WAIT_UPD, DONE.
- IDLE
  - start=1 & abort=0 → CLEAR.
  - step_idx, neuron_idx and input_idx are held at 0.
- CLEAR: acc_clr=1 for one cycle; input_idx=0 → FETCH.
- FETCH
  - rd_en=1 every cycle; input_idx increments 0..NUM_INPUTS-1.
  - After the cycle with input_idx=NUM_INPUTS-1 → DRAIN.
  - FETCH lasts exactly NUM_INPUTS cycles with no gaps.
- DRAIN
  - rd_en=0; acc_en=1 for the final input.
  - input_idx returns to 0 → UPDATE.
- UPDATE: upd_en=1 for exactly one cycle → WAIT_UPD.
- WAIT_UPD
  - Stays until upd_done=1; upd_done is sampled from the cycle after upd_en.
  - upd_done asserted in the same cycle as upd_en is ignored.
  - On upd_done, choose the next state:
    - neuron_idx<NUM_NEURONS-1: neuron_idx+1 → CLEAR.
    - else step_idx<NUM_STEPS-1: neuron_idx=0, step_idx+1 → CLEAR.
    - else → DONE.
- DONE: done=1 for one cycle; indices cleared → IDLE.
- Per-neuron cost with upd_done returned immediately is NUM_INPUTS+4 cycles. Total run = NUM_STEPS·NUM_NEURONS·(NUM_INPUTS+4) cycles from the start-sampling edge to the edge entering DONE.
- Strobe exclusivity:
  - acc_clr, acc_en and upd_en are mutually exclusive.
  - acc_en is never high in CLEAR or UPDATE.
- start while busy is ignored; it is not queued.
- abort=1 in any non-IDLE state:
  - Next state IDLE; all strobes 0 and indices 0 on that edge.
  - No done pulse.
  - An acc_en pending from the last rd_en is dropped.
- abort and start together in IDLE: abort wins, stay IDLE.
- Async reset mid-run: immediate return to IDLE with all outputs 0, no done.
- Index counters never exceed count-1; no wrap beyond the terminal value.

Test Plan:
1. Reset: rst=0 mid-FETCH (NUM_INPUTS=8, input_idx=5) → all outputs 0 within the same cycle, state IDLE; after release, no activity until start.
2. Full run with NUM_NEURONS=2, NUM_INPUTS=3, NUM_STEPS=2, upd_done tied to upd_en delayed 1 cycle:
   - done rises on the 28th edge after the start-sampling edge.
   - rd_en count=12, acc_en count=12, acc_clr count=4, upd_en count=4.
   - (step,neuron) order is (0,0),(0,1),(1,0),(1,1).
3. Update stall: upd_done held low for 10 cycles after the first upd_en → scheduler holds WAIT_UPD, indices stable, no strobes; total latency grows by exactly 9 cycles.
4. Pipeline check, NUM_INPUTS=8: input_idx sequence 0..7 on consecutive rd_en cycles; acc_en high exactly the 8 cycles following each rd_en; acc_clr precedes the first rd_en by 1 cycle.
5. Abort on the 3rd FETCH cycle of neuron 1 → next cycle IDLE, busy=0, no done. A fresh start then completes a full run with correct counts.
6. start pulsed while busy (mid-run) → no restart, counts unchanged. start+abort together in IDLE → remains IDLE, busy=0.
